// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, instruction field layout and small decode helpers shared by the CPU.
package cpu_pkg;
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_MOV  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Instruction word is {op, rd, rs1, rs2} with rs2 in the low bits.
    function automatic int instr_w(int reg_aw);
        return 4 + 3 * reg_aw;
    endfunction

    function automatic int rs1_lsb(int reg_aw);
        return reg_aw;
    endfunction

    function automatic int rd_lsb(int reg_aw);
        return 2 * reg_aw;
    endfunction

    function automatic int op_lsb(int reg_aw);
        return 3 * reg_aw;
    endfunction

    function automatic logic writes_reg(logic [3:0] op);
        return op >= OP_ADD && op <= OP_MOV;
    endfunction
endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational EX-stage ALU; LDI arrives with its immediate on b_i.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o
);
    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] sh;

    assign sh = b_i[SH_W-1:0];

    always_comb begin
        y_o = '0;
        case (op_i)
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_SHL:  y_o = a_i << sh;
            OP_SHR:  y_o = a_i >> sh;
            OP_LDI:  y_o = b_i;
            OP_MOV:  y_o = a_i;
            default: y_o = '0;
        endcase
    end
endmodule

// File: rtl/pipelined_cpu.sv
// pipelined_cpu: 3-stage IF/ID/EX CPU with EX->ID forwarding, JZ/HALT flush in EX
// and a global run-enable that freezes all state.
module pipelined_cpu
    import cpu_pkg::*;
#(
    parameter int  DATA_W  = 8,
    parameter int  REG_AW  = 4,
    parameter int  PC_W    = 8,
    localparam int INSTR_W = instr_w(REG_AW)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [DATA_W-1:0]  result,
    output logic [REG_AW-1:0]  result_reg,
    output logic               result_valid,
    output logic               halted
);
    localparam int IMM_W = 2 * REG_AW;

    logic [PC_W-1:0]    pc_q, pc_d;
    logic               ifid_v_q, idex_v_q, halted_q, result_valid_q;
    logic [INSTR_W-1:0] ifid_q;
    logic [3:0]         idex_op_q;
    logic [REG_AW-1:0]  idex_rd_q, result_reg_q;
    logic [DATA_W-1:0]  idex_a_q, idex_b_q, result_q;
    logic [IMM_W-1:0]   idex_imm_q;
    logic [DATA_W-1:0]  regs_q [2**REG_AW];

    logic [3:0]         id_op;
    logic [REG_AW-1:0]  id_rd, id_rs1, id_rs2, id_ra;
    logic [IMM_W-1:0]   id_imm;
    logic [DATA_W-1:0]  id_a, id_b, alu_y;
    logic               ex_wr, ex_jz, ex_halt, flush, run;

    assign id_op  = ifid_q[op_lsb(REG_AW) +: 4];
    assign id_rd  = ifid_q[rd_lsb(REG_AW) +: REG_AW];
    assign id_rs1 = ifid_q[rs1_lsb(REG_AW) +: REG_AW];
    assign id_rs2 = ifid_q[REG_AW-1:0];
    assign id_imm = ifid_q[IMM_W-1:0];
    assign id_ra  = (id_op == OP_JZ) ? id_rd : id_rs1;

    assign ex_wr   = idex_v_q && writes_reg(idex_op_q);
    assign ex_jz   = idex_v_q && idex_op_q == OP_JZ && idex_a_q == '0;
    assign ex_halt = idex_v_q && idex_op_q == OP_HALT;
    assign flush   = ex_jz || ex_halt;
    assign run     = en && !halted_q;

    // The EX result is not yet in the register file, so ID takes it directly.
    assign id_a = (ex_wr && idex_rd_q == id_ra) ? alu_y : regs_q[id_ra];
    assign id_b = (id_op == OP_LDI) ? DATA_W'(id_imm)
                : (ex_wr && idex_rd_q == id_rs2) ? alu_y : regs_q[id_rs2];
    assign pc_d = ex_jz ? PC_W'(idex_imm_q) : ex_halt ? pc_q : pc_q + PC_W'(1);

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i (idex_op_q),
        .a_i  (idex_a_q),
        .b_i  (idex_b_q),
        .y_o  (alu_y)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q           <= '0;
            ifid_v_q       <= 1'b0;
            ifid_q         <= '0;
            idex_v_q       <= 1'b0;
            idex_op_q      <= OP_NOP;
            idex_rd_q      <= '0;
            idex_a_q       <= '0;
            idex_b_q       <= '0;
            idex_imm_q     <= '0;
            result_q       <= '0;
            result_reg_q   <= '0;
            result_valid_q <= 1'b0;
            halted_q       <= 1'b0;
            for (int i = 0; i < 2**REG_AW; i++) regs_q[i] <= '0;
        end else begin
            result_valid_q <= run && ex_wr;
            if (run) begin
                pc_q       <= pc_d;
                ifid_v_q   <= !flush;
                ifid_q     <= imem_data;
                idex_v_q   <= ifid_v_q && !flush;
                idex_op_q  <= id_op;
                idex_rd_q  <= id_rd;
                idex_a_q   <= id_a;
                idex_b_q   <= id_b;
                idex_imm_q <= id_imm;
                halted_q   <= ex_halt;
                if (ex_wr) begin
                    regs_q[idex_rd_q] <= alu_y;
                    result_q          <= alu_y;
                    result_reg_q      <= idex_rd_q;
                end
            end
        end
    end

    assign imem_addr    = pc_q;
    assign result       = result_q;
    assign result_reg   = result_reg_q;
    assign result_valid = result_valid_q;
    assign halted       = halted_q;
endmodule

// File: tb/tb_pipelined_cpu.sv
// tb_pipelined_cpu: directed and random programs checked against an instruction-level model.
module tb_pipelined_cpu;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [7:0]  result;
    logic [3:0]  result_reg;
    logic        result_valid, halted;
    logic [15:0] mem [256];

    logic        rst2 = 1'b0;
    logic [9:0]  addr2;
    logic [15:0] data2, res2;
    logic [3:0]  reg2;
    logic        v2, h2;
    logic [15:0] mem2 [1024];

    int checks = 0;
    int passed = 0;
    logic [11:0] got[$];
    logic [11:0] exp_q[$];
    int exp_halt_addr;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];
    assign data2     = mem2[addr2];

    pipelined_cpu dut (
        .clk(clk), .rst(rst), .en(en), .imem_addr(imem_addr), .imem_data(imem_data),
        .result(result), .result_reg(result_reg), .result_valid(result_valid), .halted(halted)
    );

    pipelined_cpu #(.DATA_W(16), .REG_AW(4), .PC_W(10)) dut2 (
        .clk(clk), .rst(rst2), .en(en), .imem_addr(addr2), .imem_data(data2),
        .result(res2), .result_reg(reg2), .result_valid(v2), .halted(h2)
    );

    always @(negedge clk) if (rst && result_valid) got.push_back({result_reg, result});

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [15:0] enc(int op, int rd, int imm);
        return {op[3:0], rd[3:0], imm[7:0]};
    endfunction

    function automatic logic [15:0] enc3(int op, int rd, int s1, int s2);
        return enc(op, rd, s1 * 16 + s2);
    endfunction

    function automatic int stream_errs();
        int e = (got.size() > exp_q.size()) ? got.size() - exp_q.size() : exp_q.size() - got.size();
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) e++;
        return e;
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fill(logic [15:0] w);
        foreach (mem[i]) mem[i] = w;
    endtask

    task automatic start();
        rst = 1'b0;
        en  = 1'b1;
        step(1);
        got.delete();
        rst = 1'b1;
    endtask

    task automatic wait_halt(input bit rnd, output bit ok);
        int n = 0;
        while (!halted && n < 3000) begin
            en = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            step(1);
            n++;
        end
        en = 1'b1;
        ok = halted;
    endtask

    // Architectural execution: one instruction at a time, no pipeline.
    task automatic model_run();
        logic [7:0] r [16];
        int pc = 0;
        exp_q.delete();
        exp_halt_addr = -1;
        foreach (r[i]) r[i] = '0;
        for (int n = 0; n < 5000; n++) begin
            logic [15:0] w;
            int op, rd, a, b, y;
            w  = mem[pc];
            op = int'(w[15:12]);
            rd = int'(w[11:8]);
            a  = int'(r[w[7:4]]);
            b  = int'(r[w[3:0]]);
            if (op == 15) begin
                exp_halt_addr = (pc + 2) % 256;
                return;
            end
            if (op == 10) begin
                pc = (r[rd] == 0) ? int'(w[7:0]) : (pc + 1) % 256;
                continue;
            end
            pc = (pc + 1) % 256;
            if (op < 1 || op > 9) continue;
            case (op)
                1: y = a + b;
                2: y = a - b;
                3: y = a & b;
                4: y = a | b;
                5: y = a ^ b;
                6: y = a << (b % 8);
                7: y = a >> (b % 8);
                8: y = int'(w[7:0]);
                default: y = a;
            endcase
            r[rd] = y[7:0];
            exp_q.push_back({w[11:8], y[7:0]});
        end
    endtask

    task automatic test_reset();
        bit ok;
        for (int i = 0; i < 256; i++) mem[i] = enc(8, i % 16, $urandom_range(1, 255));
        start();
        step(12);
        rst = 1'b0;
        #1;
        checks++;
        if ({imem_addr, result, result_valid, halted} !== 18'h0)
            $display("FAIL reset_outputs: got addr=%0h res=%0h v=%0b h=%0b, expected all 0", imem_addr, result, result_valid, halted);
        else passed++;
        fill(16'h0000);
        for (int i = 0; i < 16; i++) mem[i] = enc3(9, i, i, 0);
        mem[16] = 16'hF000;
        step(2);
        got.delete();
        rst = 1'b1;
        checks++;
        if (imem_addr !== 8'h00) $display("FAIL reset_addr: got %0h expected 0", imem_addr);
        else passed++;
        wait_halt(0, ok);
        model_run();
        checks++;
        if (ok !== 1'b1) $display("FAIL reset_halt_timeout: halted=%0b expected 1", halted);
        else passed++;
        checks++;
        if (stream_errs() !== 0) $display("FAIL reset_regs_zero: %0d mismatches, got %0d writes expected %0d", stream_errs(), got.size(), exp_q.size());
        else passed++;
    endtask

    task automatic test_basic();
        logic [7:0] ea [5] = '{8'h05, 8'h03, 8'h08, 8'hFE, 8'h28};
        logic [3:0] er [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        fill(16'h0000);
        mem[0] = enc(8, 1, 5);
        mem[1] = enc(8, 2, 3);
        mem[2] = enc3(1, 3, 1, 2);
        mem[3] = enc3(2, 4, 2, 1);
        mem[4] = enc3(6, 5, 1, 2);
        mem[5] = 16'hF000;
        start();
        step(2);
        checks++;
        if (result_valid !== 1'b0) $display("FAIL basic_latency: result_valid=%0b at cycle 2, expected 0", result_valid);
        else passed++;
        for (int k = 0; k < 5; k++) begin
            step(1);
            checks++;
            if ({result_valid, result_reg, result} !== {1'b1, er[k], ea[k]})
                $display("FAIL basic_pulse%0d: got v=%0b r%0d=%0h expected v=1 r%0d=%0h", k, result_valid, result_reg, result, er[k], ea[k]);
            else passed++;
        end
        step(1);
        checks++;
        if ({halted, result_valid, imem_addr} !== {1'b1, 1'b0, 8'h07})
            $display("FAIL basic_halt: got h=%0b v=%0b addr=%0h expected h=1 v=0 addr=07", halted, result_valid, imem_addr);
        else passed++;
        model_run();
        checks++;
        if (stream_errs() !== 0) $display("FAIL basic_stream: %0d mismatches", stream_errs());
        else passed++;
    endtask

    task automatic test_jz_halt();
        fill(enc(8, 15, 8'hEE));
        mem[0] = enc(8, 1, 7);
        mem[1] = enc(8, 2, 2);
        for (int i = 2; i < 6; i++) mem[i] = 16'h0000;
        mem[6] = enc(10, 0, 8'h10);
        mem[7] = enc(8, 9, 8'hAA);
        mem[8] = enc(8, 10, 8'hBB);
        mem[16] = enc(10, 1, 8'h30);
        mem[17] = 16'hF000;
        mem[18] = enc(8, 3, 8'h33);
        start();
        step(8);
        checks++;
        if (imem_addr !== 8'h08) $display("FAIL jz_before: addr=%0h expected 08", imem_addr);
        else passed++;
        step(1);
        checks++;
        if (imem_addr !== 8'h10) $display("FAIL jz_target: addr=%0h expected 10", imem_addr);
        else passed++;
        for (int c = 9; c < 13; c++) begin
            if (c > 9) step(1);
            checks++;
            if (result_valid !== 1'b0 || halted !== 1'b0)
                $display("FAIL jz_bubble_c%0d: v=%0b h=%0b expected 0 0", c, result_valid, halted);
            else passed++;
        end
        step(1);
        checks++;
        if ({halted, imem_addr} !== {1'b1, 8'h13}) $display("FAIL halt_set: h=%0b addr=%0h expected 1 13", halted, imem_addr);
        else passed++;
        step(5);
        checks++;
        if ({halted, result_valid, imem_addr} !== {1'b1, 1'b0, 8'h13})
            $display("FAIL halt_frozen: h=%0b v=%0b addr=%0h expected 1 0 13", halted, result_valid, imem_addr);
        else passed++;
        model_run();
        checks++;
        if (stream_errs() !== 0 || got.size() !== 2) $display("FAIL jz_stream: %0d mismatches, %0d writes expected 2", stream_errs(), got.size());
        else passed++;
    endtask

    task automatic test_en_stall();
        logic [7:0] sa, sr;
        bit ok;
        fill(16'h0000);
        mem[0] = enc(8, 1, 5);
        mem[1] = enc(8, 2, 3);
        mem[2] = enc3(1, 3, 1, 2);
        mem[3] = enc3(2, 4, 3, 1);
        mem[4] = enc3(5, 5, 4, 3);
        mem[5] = enc3(4, 6, 5, 1);
        mem[6] = enc3(3, 7, 6, 2);
        mem[7] = enc3(7, 8, 6, 2);
        mem[8] = enc3(9, 9, 8, 0);
        mem[9] = enc3(1, 9, 9, 9);
        mem[10] = 16'hF000;
        start();
        step(4);
        en = 1'b0;
        sa = imem_addr;
        sr = result;
        for (int c = 0; c < 5; c++) begin
            step(1);
            checks++;
            if ({imem_addr, result, result_valid} !== {sa, sr, 1'b0})
                $display("FAIL stall_hold%0d: addr=%0h res=%0h v=%0b expected %0h %0h 0", c, imem_addr, result, result_valid, sa, sr);
            else passed++;
        end
        en = 1'b1;
        wait_halt(0, ok);
        model_run();
        checks++;
        if (ok !== 1'b1) $display("FAIL stall_timeout: halted=%0b expected 1", halted);
        else passed++;
        checks++;
        if (stream_errs() !== 0) $display("FAIL stall_stream: %0d mismatches, got %0d writes expected %0d", stream_errs(), got.size(), exp_q.size());
        else passed++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            int len;
            bit ok;
            len = $urandom_range(8, 60);
            for (int i = 0; i < 256; i++) mem[i] = enc($urandom_range(1, 9), $urandom_range(0, 15), $urandom_range(0, 255));
            for (int i = 0; i < len - 1; i++) begin
                int op = $urandom_range(0, 14);
                if (op == 10) mem[i] = enc(10, $urandom_range(0, 3), $urandom_range(i + 1, len - 1));
                else if (op == 8) mem[i] = enc(8, $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255));
                else mem[i] = enc3(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            end
            mem[len - 1] = 16'hF000;
            model_run();
            start();
            wait_halt(1, ok);
            step(3);
            checks++;
            if (ok !== 1'b1) $display("FAIL rand%0d_timeout: halted=%0b expected 1", it, halted);
            else passed++;
            checks++;
            if (stream_errs() !== 0) $display("FAIL rand%0d_stream: %0d mismatches, got %0d writes expected %0d", it, stream_errs(), got.size(), exp_q.size());
            else passed++;
            checks++;
            if (int'(imem_addr) !== exp_halt_addr) $display("FAIL rand%0d_halt_addr: addr=%0h expected %0h", it, imem_addr, exp_halt_addr);
            else passed++;
        end
    endtask

    task automatic test_wide();
        int n = 0;
        en = 1'b1;
        foreach (mem2[i]) mem2[i] = 16'h0000;
        mem2[0] = enc(8, 1, 8'hFF);
        mem2[1] = enc3(1, 1, 1, 1);
        rst2 = 1'b0;
        step(1);
        rst2 = 1'b1;
        step(3);
        checks++;
        if ({v2, reg2, res2} !== {1'b1, 4'd1, 16'h00FF}) $display("FAIL wide_ldi: v=%0b r%0d=%0h expected v=1 r1=00ff", v2, reg2, res2);
        else passed++;
        step(1);
        checks++;
        if ({v2, reg2, res2} !== {1'b1, 4'd1, 16'h01FE}) $display("FAIL wide_add: v=%0b r%0d=%0h expected v=1 r1=01fe", v2, reg2, res2);
        else passed++;
        while (addr2 !== 10'h3FF && n < 1200) begin
            step(1);
            n++;
        end
        checks++;
        if (addr2 !== 10'h3FF) $display("FAIL wide_reach_top: addr=%0h expected 3ff", addr2);
        else passed++;
        step(1);
        checks++;
        if (addr2 !== 10'h000 || h2 !== 1'b0) $display("FAIL wide_wrap: addr=%0h h=%0b expected 000 0", addr2, h2);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_jz_halt();
        test_en_stall();
        test_random();
        test_wide();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
